mem_arbiter: RTL



---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory port arbiter: address width,
// IO region decode value and the response-owner encoding.
package mem_pkg;

    localparam int         ADDR_W    = 18;
    localparam logic [1:0] IO_REGION = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DC   = 2'd1,
        OWN_IC   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, RAM-port and debug signals around mem_arbiter.
// slave = arbiter side, master = requesters plus RAM/IO side.
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W
) ();

    // Handshake: a requester raises get_en with addr (and write data) and holds
    // them unchanged until its out_en pulses; in that out_en cycle it may present
    // the next byte or drop get_en. out_en is a single-cycle strobe, one cycle
    // after the byte was issued, and read data is valid only while it is high.
    logic              rdy;
    logic              io_buffer_full;

    logic              dc_get_en;
    logic              dc_write;
    logic [ADDR_W-1:0] dc_addr;
    logic [7:0]        dc_wdata;
    logic              dc_out_en;
    logic [7:0]        dc_rdata;

    logic              ic_get_en;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_out_en;
    logic [7:0]        ic_rdata;

    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    owner_t            dbg_resp_owner;

    modport slave (
        input  rdy, io_buffer_full,
        input  dc_get_en, dc_write, dc_addr, dc_wdata,
        output dc_out_en, dc_rdata,
        input  ic_get_en, ic_addr,
        output ic_out_en, ic_rdata,
        output ram_a, ram_wr, ram_dout,
        input  ram_din,
        output dbg_resp_owner
    );

    modport master (
        output rdy, io_buffer_full,
        output dc_get_en, dc_write, dc_addr, dc_wdata,
        input  dc_out_en, dc_rdata,
        output ic_get_en, ic_addr,
        input  ic_out_en, ic_rdata,
        input  ram_a, ram_wr, ram_dout,
        output ram_din,
        input  dbg_resp_owner
    );

endinterface

// File: rtl/mem_arbiter.sv
// Byte-per-cycle arbiter sharing one RAM/IO port between dcache and icache.
// Optional icache starvation guard is built when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    owner_t resp_owner;
    owner_t resp_owner_nxt;
    owner_t grant;
    logic   io_block;
    logic   force_ic;

    // A dc write into the IO region waits while the IO FIFO is full; icache may proceed.
    always_comb begin
        io_block = bus.dc_write
                 && (bus.dc_addr[ADDR_W-1 -: 2] == IO_REGION)
                 && bus.io_buffer_full;
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    // Saturates one past LIMIT-1 so the forced grant survives rdy=0 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.ic_get_en || (grant == OWN_IC)) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        force_ic = bus.ic_get_en && (starve_cnt == CNT_W'(STARVE_LIMIT));
    end
`else
    always_comb begin
        force_ic = 1'b0;
    end
`endif

    // Grant decision doubles as the next response owner.
    always_comb begin
        grant = OWN_NONE;
        if (!rst && bus.rdy) begin
            if (force_ic) begin
                grant = OWN_IC;
            end else if (bus.dc_get_en && !io_block) begin
                grant = OWN_DC;
            end else if (bus.ic_get_en) begin
                grant = OWN_IC;
            end
        end
        resp_owner_nxt = grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_owner <= OWN_NONE;
        end else begin
            resp_owner <= resp_owner_nxt;
        end
    end

    always_comb begin
        bus.ram_a    = '0;
        bus.ram_wr   = 1'b0;
        bus.ram_dout = 8'h00;
        case (grant)
            OWN_DC: begin
                bus.ram_a    = bus.dc_addr;
                bus.ram_wr   = bus.dc_write;
                bus.ram_dout = bus.dc_write ? bus.dc_wdata : 8'h00;
            end
            OWN_IC: begin
                bus.ram_a = bus.ic_addr;
            end
            default: begin
                bus.ram_a = '0;
            end
        endcase
    end

    // Strobes follow the registered owner, so each byte completes exactly one cycle after issue.
    always_comb begin
        bus.dc_out_en      = (resp_owner == OWN_DC);
        bus.ic_out_en      = (resp_owner == OWN_IC);
        bus.dc_rdata       = bus.ram_din;
        bus.ic_rdata       = bus.ram_din;
        bus.dbg_resp_owner = resp_owner;
    end

    a_one_strobe : assert property (@(posedge clk) disable iff (rst)
        !(bus.dc_out_en && bus.ic_out_en));

    a_dout_idle_zero : assert property (@(posedge clk) disable iff (rst)
        !bus.ram_wr |-> (bus.ram_dout == 8'h00));

endmodule
